// File: rtl/cp0_tlb_pkg.sv
// Shared definitions for the CP0 TLB controller: command codes, CP0 register numbers,
// register field positions and mtc0 write masks, FSM state encoding and the TLB entry struct.
// No logic of its own.
package cp0_tlb_pkg;

    // cmd_op encodings
    localparam logic [1:0] OP_TLBP  = 2'b00;
    localparam logic [1:0] OP_TLBR  = 2'b01;
    localparam logic [1:0] OP_TLBWI = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    // CP0 register numbers
    localparam logic [4:0] CP0_INDEX    = 5'd0;
    localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
    localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
    localparam logic [4:0] CP0_ENTRYHI  = 5'd10;

    // Field positions
    localparam int INDEX_P_BIT   = 31;
    localparam int EHI_VPN2_LSB  = 13;
    localparam int ELO_PFN_LSB   = 6;
    localparam int ELO_C_LSB     = 3;
    localparam int ELO_D_BIT     = 2;
    localparam int ELO_V_BIT     = 1;
    localparam int ELO_G_BIT     = 0;

    // mtc0 write masks (Index mask depends on the TLB size and is built in cp0_tlb_regs)
    localparam logic [31:0] ENTRYHI_WMASK = 32'hFFFF_E0FF;
    localparam logic [31:0] ENTRYLO_WMASK = 32'h03FF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PROBE = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_NOP   = 3'd4
    } state_t;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

endpackage

// File: rtl/cp0_tlb_regs.sv
// Index/EntryHi/EntryLo0/EntryLo1 storage with masked mtc0 writes and a combinational mfc0 mux.
// Latency: mtc0 and FSM captures take effect at the next edge; mfc0 and entry outputs are combinational.
// Backpressure: none; writes are always accepted, a same-edge FSM capture overrides an mtc0 to that register.
// Ports: mtc0_* write port, mfc0_* read port, probe_*/read_* capture inputs, index/entry views for the TLB ports.
module cp0_tlb_regs
    import cp0_tlb_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             mtc0_we,
    input  logic [4:0]       mtc0_addr,
    input  logic [31:0]      mtc0_wdata,
    input  logic [4:0]       mfc0_addr,
    output logic [31:0]      mfc0_rdata,
    input  logic             probe_en,
    input  logic             probe_found,
    input  logic [IDX_W-1:0] probe_index,
    input  logic             read_en,
    input  tlb_entry_t       read_entry,
    output logic [IDX_W-1:0] index,
    output tlb_entry_t       entry
);

    logic             idx_p;
    logic [IDX_W-1:0] idx;
    logic [31:0]      entry_hi;
    logic [31:0]      entry_lo0;
    logic [31:0]      entry_lo1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx_p     <= 1'b0;
            idx       <= '0;
            entry_hi  <= '0;
            entry_lo0 <= '0;
            entry_lo1 <= '0;
        end else begin
            if (mtc0_we) begin
                case (mtc0_addr)
                    CP0_INDEX:    idx       <= mtc0_wdata[IDX_W-1:0];
                    CP0_ENTRYHI:  entry_hi  <= mtc0_wdata & ENTRYHI_WMASK;
                    CP0_ENTRYLO0: entry_lo0 <= mtc0_wdata & ENTRYLO_WMASK;
                    CP0_ENTRYLO1: entry_lo1 <= mtc0_wdata & ENTRYLO_WMASK;
                    default: ;
                endcase
            end
            // Captures come after the mtc0 decode so the later non-blocking write wins.
            if (probe_en) begin
                idx_p <= ~probe_found;
                // On a miss the old idx is re-written explicitly to discard a same-edge mtc0.
                idx   <= probe_found ? probe_index : idx;
            end
            if (read_en) begin
                entry_hi  <= {read_entry.vpn2, 5'b0, read_entry.asid};
                entry_lo0 <= {6'b0, read_entry.pfn0, read_entry.c0, read_entry.d0,
                              read_entry.v0, read_entry.g};
                entry_lo1 <= {6'b0, read_entry.pfn1, read_entry.c1, read_entry.d1,
                              read_entry.v1, read_entry.g};
            end
        end
    end

    always_comb begin
        mfc0_rdata = '0;
        case (mfc0_addr)
            CP0_INDEX:    mfc0_rdata = {idx_p, {(31-IDX_W){1'b0}}, idx};
            CP0_ENTRYHI:  mfc0_rdata = entry_hi;
            CP0_ENTRYLO0: mfc0_rdata = entry_lo0;
            CP0_ENTRYLO1: mfc0_rdata = entry_lo1;
            default:      mfc0_rdata = '0;
        endcase
    end

    assign index      = idx;
    assign entry.vpn2 = entry_hi[31:EHI_VPN2_LSB];
    assign entry.asid = entry_hi[7:0];
    // The TLB holds a single G bit; the entry is global only if both halves say so.
    assign entry.g    = entry_lo0[ELO_G_BIT] & entry_lo1[ELO_G_BIT];
    assign entry.pfn0 = entry_lo0[25:ELO_PFN_LSB];
    assign entry.c0   = entry_lo0[ELO_C_LSB+2:ELO_C_LSB];
    assign entry.d0   = entry_lo0[ELO_D_BIT];
    assign entry.v0   = entry_lo0[ELO_V_BIT];
    assign entry.pfn1 = entry_lo1[25:ELO_PFN_LSB];
    assign entry.c1   = entry_lo1[ELO_C_LSB+2:ELO_C_LSB];
    assign entry.d1   = entry_lo1[ELO_D_BIT];
    assign entry.v1   = entry_lo1[ELO_V_BIT];

endmodule

// File: rtl/cp0_tlb_ctrl.sv
// CP0-side TLB controller: architectural TLB registers plus TLBP/TLBR/TLBWI command sequencing.
// Latency: command accepted at E0, executes E0-E1, results/TLB write at E1, done pulse E1-E2.
// Backpressure: cmd_ready only in IDLE, so at most one command per two cycles; mtc0 never stalls.
// Ports: cmd_*/done command handshake, mtc0_*/mfc0_* CP0 access, s1_* search, r_* read, w_*/we write.
module cp0_tlb_ctrl
    import cp0_tlb_pkg::*;
#(
    parameter int TLBNUM = 16,
    parameter int IDX_W  = $clog2(TLBNUM)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    output logic             cmd_ready,
    output logic             done,
    input  logic             mtc0_we,
    input  logic [4:0]       mtc0_addr,
    input  logic [31:0]      mtc0_wdata,
    input  logic [4:0]       mfc0_addr,
    output logic [31:0]      mfc0_rdata,
    output logic [18:0]      s1_vpn2,
    output logic             s1_odd_page,
    output logic [7:0]       s1_asid,
    input  logic             s1_found,
    input  logic [IDX_W-1:0] s1_index,
    output logic [IDX_W-1:0] r_index,
    input  logic [18:0]      r_vpn2,
    input  logic [7:0]       r_asid,
    input  logic             r_g,
    input  logic [19:0]      r_pfn0,
    input  logic [2:0]       r_c0,
    input  logic             r_d0,
    input  logic             r_v0,
    input  logic [19:0]      r_pfn1,
    input  logic [2:0]       r_c1,
    input  logic             r_d1,
    input  logic             r_v1,
    output logic             we,
    output logic [IDX_W-1:0] w_index,
    output logic [18:0]      w_vpn2,
    output logic [7:0]       w_asid,
    output logic             w_g,
    output logic [19:0]      w_pfn0,
    output logic [2:0]       w_c0,
    output logic             w_d0,
    output logic             w_v0,
    output logic [19:0]      w_pfn1,
    output logic [2:0]       w_c1,
    output logic             w_d1,
    output logic             w_v1
);

    state_t           state;
    tlb_entry_t       read_entry;
    tlb_entry_t       entry;
    logic [IDX_W-1:0] index;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            // Each operation state lasts one cycle, so done simply follows "was busy".
            done <= (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_TLBP:  state <= ST_PROBE;
                            OP_TLBR:  state <= ST_READ;
                            OP_TLBWI: state <= ST_WRITE;
                            default:  state <= ST_NOP;
                        endcase
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state == ST_IDLE);
    // Decoded from the state register so an async reset removes the strobe before the edge.
    assign we        = (state == ST_WRITE);

    assign read_entry = {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
                         r_pfn1, r_c1, r_d1, r_v1};

    cp0_tlb_regs #(
        .IDX_W (IDX_W)
    ) u_regs (
        .clk         (clk),
        .resetn      (resetn),
        .mtc0_we     (mtc0_we),
        .mtc0_addr   (mtc0_addr),
        .mtc0_wdata  (mtc0_wdata),
        .mfc0_addr   (mfc0_addr),
        .mfc0_rdata  (mfc0_rdata),
        .probe_en    (state == ST_PROBE),
        .probe_found (s1_found),
        .probe_index (s1_index),
        .read_en     (state == ST_READ),
        .read_entry  (read_entry),
        .index       (index),
        .entry       (entry)
    );

    assign s1_vpn2     = entry.vpn2;
    assign s1_asid     = entry.asid;
    assign s1_odd_page = 1'b0;
    assign r_index     = index;

    assign w_index = index;
    assign w_vpn2  = entry.vpn2;
    assign w_asid  = entry.asid;
    assign w_g     = entry.g;
    assign w_pfn0  = entry.pfn0;
    assign w_c0    = entry.c0;
    assign w_d0    = entry.d0;
    assign w_v0    = entry.v0;
    assign w_pfn1  = entry.pfn1;
    assign w_c1    = entry.c1;
    assign w_d1    = entry.d1;
    assign w_v1    = entry.v1;

endmodule

// File: tb/tb_cp0_tlb_ctrl.sv
// Self-checking bench for cp0_tlb_ctrl: directed scenarios followed by random mtc0/command traffic.
// The reference keeps the four architectural registers as 32-bit words and applies the register rules.
// TLB stubs are plain bench variables driven before each command.
module tb_cp0_tlb_ctrl;

    localparam int TLBNUM = 16;
    localparam int IDX_W  = 4;

    localparam logic [1:0] C_TLBP = 2'b00, C_TLBR = 2'b01, C_TLBWI = 2'b10, C_NOP = 2'b11;
    localparam logic [4:0] R_INDEX = 5'd0, R_LO0 = 5'd2, R_LO1 = 5'd3, R_HI = 5'd10;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_op = 2'b11;
    logic             cmd_ready, done;
    logic             mtc0_we = 1'b0;
    logic [4:0]       mtc0_addr = '0;
    logic [31:0]      mtc0_wdata = '0;
    logic [4:0]       mfc0_addr = '0;
    logic [31:0]      mfc0_rdata;
    logic [18:0]      s1_vpn2;
    logic             s1_odd_page;
    logic [7:0]       s1_asid;
    logic             s1_found = 1'b0;
    logic [IDX_W-1:0] s1_index = '0;
    logic [IDX_W-1:0] r_index;
    logic [18:0]      r_vpn2 = '0;
    logic [7:0]       r_asid = '0;
    logic             r_g = 1'b0;
    logic [19:0]      r_pfn0 = '0, r_pfn1 = '0;
    logic [2:0]       r_c0 = '0, r_c1 = '0;
    logic             r_d0 = 1'b0, r_v0 = 1'b0, r_d1 = 1'b0, r_v1 = 1'b0;
    logic             we;
    logic [IDX_W-1:0] w_index;
    logic [18:0]      w_vpn2;
    logic [7:0]       w_asid;
    logic             w_g;
    logic [19:0]      w_pfn0, w_pfn1;
    logic [2:0]       w_c0, w_c1;
    logic             w_d0, w_v0, w_d1, w_v1;

    int n_assert = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;

    // Reference register file
    logic [31:0] m_index = '0, m_hi = '0, m_lo0 = '0, m_lo1 = '0;

    always #5 clk = ~clk;

    always @(posedge clk) if (we === 1'b1) wr_cnt <= wr_cnt + 1;

    cp0_tlb_ctrl #(.TLBNUM(TLBNUM)) dut (
        .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_ready(cmd_ready), .done(done), .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr),
        .mtc0_wdata(mtc0_wdata), .mfc0_addr(mfc0_addr), .mfc0_rdata(mfc0_rdata),
        .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index), .r_index(r_index),
        .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g), .r_pfn0(r_pfn0), .r_c0(r_c0),
        .r_d0(r_d0), .r_v0(r_v0), .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
        .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
        .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
        .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void apply_mtc0(input logic [4:0] a, input logic [31:0] d);
        case (a)
            R_INDEX: m_index = (m_index & 32'h8000_0000) | (d % TLBNUM);
            R_HI:    m_hi    = d & 32'hFFFF_E0FF;
            R_LO0:   m_lo0   = d & 32'h03FF_FFFF;
            R_LO1:   m_lo1   = d & 32'h03FF_FFFF;
            default: ;
        endcase
    endfunction

    function automatic logic [4:0] pick_addr();
        case ($urandom_range(0, 4))
            0:       return R_INDEX;
            1:       return R_LO0;
            2:       return R_LO1;
            3:       return R_HI;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        mfc0_addr = a;
        #1;
        chk(tag, mfc0_rdata, exp);
    endtask

    task automatic check_all(input string tag);
        rd({tag, ".index"}, R_INDEX, m_index);
        rd({tag, ".hi"},    R_HI,    m_hi);
        rd({tag, ".lo0"},   R_LO0,   m_lo0);
        rd({tag, ".lo1"},   R_LO1,   m_lo1);
        rd({tag, ".unimp"}, 5'd12,   32'h0);
        chk({tag, ".s1_vpn2"}, 32'(s1_vpn2), m_hi >> 13);
        chk({tag, ".s1_asid"}, 32'(s1_asid), m_hi % 256);
        chk({tag, ".r_index"}, 32'(r_index), m_index % TLBNUM);
        chk({tag, ".w_g"},     32'(w_g),     32'(m_lo0[0] & m_lo1[0]));
    endtask

    task automatic mtc0_wr(input logic [4:0] a, input logic [31:0] d);
        mtc0_we = 1'b1; mtc0_addr = a; mtc0_wdata = d;
        step();
        mtc0_we = 1'b0;
        apply_mtc0(a, d);
    endtask

    // Issue one command; optionally drive an mtc0 during its operation cycle.
    task automatic do_cmd(input logic [1:0] op, input bit w, input logic [4:0] wa, input logic [31:0] wd);
        int guard = 0;
        int wr0;
        logic [31:0] pre_index;
        while (cmd_ready !== 1'b1 && guard < 20) begin step(); guard++; end
        chk("cmd.ready_before", 32'(cmd_ready), 32'd1);
        wr0 = wr_cnt;
        cmd_valid = 1'b1; cmd_op = op;
        step();
        cmd_valid = 1'b0;
        chk("cmd.busy", 32'(cmd_ready), 32'd0);
        chk("cmd.we_op", 32'(we), 32'(op == C_TLBWI));
        chk("cmd.s1_vpn2_pre", 32'(s1_vpn2), m_hi >> 13);
        if (op == C_TLBWI) begin
            chk("wr.index", 32'(w_index), m_index % TLBNUM);
            chk("wr.vpn2",  32'(w_vpn2),  m_hi >> 13);
            chk("wr.asid",  32'(w_asid),  m_hi % 256);
            chk("wr.pfn0",  32'(w_pfn0),  m_lo0 >> 6);
            chk("wr.c0",    32'(w_c0),    (m_lo0 >> 3) % 8);
            chk("wr.dv0",   32'({w_d0, w_v0}), (m_lo0 >> 1) % 4);
            chk("wr.pfn1",  32'(w_pfn1),  m_lo1 >> 6);
            chk("wr.c1",    32'(w_c1),    (m_lo1 >> 3) % 8);
            chk("wr.dv1",   32'({w_d1, w_v1}), (m_lo1 >> 1) % 4);
        end
        if (w) begin mtc0_we = 1'b1; mtc0_addr = wa; mtc0_wdata = wd; end
        step();
        mtc0_we = 1'b0;
        pre_index = m_index;
        if (w) apply_mtc0(wa, wd);
        case (op)
            C_TLBP: m_index = s1_found ? 32'(s1_index) : (pre_index | 32'h8000_0000);
            C_TLBR: begin
                m_hi  = (32'(r_vpn2) << 13) | 32'(r_asid);
                m_lo0 = (32'(r_pfn0) << 6) | (32'(r_c0) << 3) | (32'(r_d0) << 2) | (32'(r_v0) << 1) | 32'(r_g);
                m_lo1 = (32'(r_pfn1) << 6) | (32'(r_c1) << 3) | (32'(r_d1) << 2) | (32'(r_v1) << 1) | 32'(r_g);
            end
            default: ;
        endcase
        chk("cmd.done", 32'(done), 32'd1);
        chk("cmd.ready_after", 32'(cmd_ready), 32'd1);
        chk("cmd.we_after", 32'(we), 32'd0);
        chk("cmd.wr_count", 32'(wr_cnt - wr0), 32'(op == C_TLBWI));
        step();
        chk("cmd.done_pulse", 32'(done), 32'd0);
    endtask

    task automatic randomize_stubs();
        s1_found = 1'($urandom_range(0, 1));
        s1_index = IDX_W'($urandom_range(0, TLBNUM - 1));
        r_vpn2 = 19'($urandom); r_asid = 8'($urandom); r_g = 1'($urandom);
        r_pfn0 = 20'($urandom); r_c0 = 3'($urandom); r_d0 = 1'($urandom); r_v0 = 1'($urandom);
        r_pfn1 = 20'($urandom); r_c1 = 3'($urandom); r_d1 = 1'($urandom); r_v1 = 1'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        // Reset
        #3;
        chk("rst.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst.we", 32'(we), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        step(); step();
        resetn = 1'b1;
        step();
        check_all("rst");
        chk("rst.w_vpn2", 32'(w_vpn2), 32'd0);
        chk("rst.s1_odd", 32'(s1_odd_page), 32'd0);

        // TLBWI with fixed values
        mtc0_wr(R_INDEX, 32'd3);
        mtc0_wr(R_HI,    32'h8000_2042);
        mtc0_wr(R_LO0,   32'h17);
        mtc0_wr(R_LO1,   32'h47);
        rd("wi.hi_readback", R_HI, 32'h8000_2042);
        chk("wi.w_index", 32'(w_index), 32'd3);
        chk("wi.w_vpn2", 32'(w_vpn2), 32'h40001);
        chk("wi.w_asid", 32'(w_asid), 32'h42);
        chk("wi.w_g", 32'(w_g), 32'd1);
        chk("wi.lo0", 32'({w_pfn0, w_c0, w_d0, w_v0}), {20'd0, 3'd2, 1'b1, 1'b1});
        chk("wi.lo1", 32'({w_pfn1, w_c1}), {20'd1, 3'd0});
        do_cmd(C_TLBWI, 1'b0, 5'd0, 32'd0);
        check_all("wi");

        // TLBP hit then miss
        s1_found = 1'b1; s1_index = 4'd5;
        do_cmd(C_TLBP, 1'b0, 5'd0, 32'd0);
        rd("probe.hit", R_INDEX, 32'h5);
        s1_found = 1'b0; s1_index = 4'd9;
        do_cmd(C_TLBP, 1'b0, 5'd0, 32'd0);
        rd("probe.miss", R_INDEX, 32'h8000_0005);
        mtc0_wr(R_INDEX, 32'hFFFF_FFF3);
        rd("index.p_not_writable", R_INDEX, 32'h8000_0003);

        // TLBR
        r_vpn2 = 19'h7FFFF; r_asid = 8'hAA; r_g = 1'b0; r_pfn0 = 20'hFFFFF;
        r_c0 = 3'd3; r_d0 = 1'b0; r_v0 = 1'b1;
        chk("read.r_index", 32'(r_index), 32'd3);
        do_cmd(C_TLBR, 1'b0, 5'd0, 32'd0);
        rd("read.hi", R_HI, 32'hFFFF_E0AA);
        rd("read.lo0", R_LO0, 32'h03FF_FFDA);
        check_all("read");

        // mtc0 EntryHi during PROBE: probe uses the old EntryHi, new value visible after
        s1_found = 1'b1; s1_index = 4'd2;
        do_cmd(C_TLBP, 1'b1, R_HI, 32'h1234_5678);
        check_all("probe_mtc0");
        // Same-edge mtc0 to EntryLo0 during TLBR: capture wins
        randomize_stubs();
        do_cmd(C_TLBR, 1'b1, R_LO0, 32'h0155_5555);
        check_all("read_mtc0");

        // Back-to-back TLBPs with cmd_valid held
        cmd_valid = 1'b1; cmd_op = C_TLBP; s1_found = 1'b1; s1_index = 4'd9;
        step();
        chk("b2b.busy1", 32'(cmd_ready), 32'd0);
        step();
        chk("b2b.done1", 32'(done), 32'd1);
        chk("b2b.ready1", 32'(cmd_ready), 32'd1);
        s1_index = 4'd7;
        step();
        chk("b2b.busy2", 32'(cmd_ready), 32'd0);
        rd("b2b.index1", R_INDEX, 32'd9);
        cmd_valid = 1'b0;
        step();
        chk("b2b.done2", 32'(done), 32'd1);
        m_index = 32'd7;
        step();
        check_all("b2b");

        // Reset during WRITE
        wr0 = wr_cnt;
        cmd_valid = 1'b1; cmd_op = C_TLBWI;
        step();
        cmd_valid = 1'b0;
        chk("rstmid.we_before", 32'(we), 32'd1);
        resetn = 1'b0;
        #1;
        chk("rstmid.we_async", 32'(we), 32'd0);
        chk("rstmid.done", 32'(done), 32'd0);
        chk("rstmid.ready", 32'(cmd_ready), 32'd1);
        step();
        chk("rstmid.no_write", 32'(wr_cnt - wr0), 32'd0);
        resetn = 1'b1;
        m_index = '0; m_hi = '0; m_lo0 = '0; m_lo1 = '0;
        step();
        chk("rstmid.done_after", 32'(done), 32'd0);
        check_all("rstmid");
        do_cmd(C_NOP, 1'b0, 5'd0, 32'd0);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                mtc0_wr(pick_addr(), $urandom);
                check_all("rnd_mtc0");
            end else begin
                randomize_stubs();
                do_cmd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), pick_addr(), $urandom);
                check_all("rnd_cmd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
